// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if
//   Groups the bus-side signals of the RAM burst reader into one interface:
//     command channel : cmd_valid, cmd_ready, cmd_addr, cmd_len
//     RAM read port   : ram_addr_rd (address out), ram_dout (async data in)
//     output stream   : out_valid, out_ready, out_data, out_last
//     status          : busy, done
//   With RAM_BURST_READER_BOUNDS_EN defined, cmd_err is added to the status group.
//   Modports:
//     master : the burst engine side (drives cmd_ready, RAM address, stream, status)
//     slave  : the environment side (command source, RAM, stream consumer)
interface ram_burst_reader_if #(
  parameter int addr_width = 2,
  parameter int data_width = 2
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [addr_width-1:0] cmd_addr;
  logic [addr_width:0]   cmd_len;
  logic [addr_width-1:0] ram_addr_rd;
  logic [data_width-1:0] ram_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
`ifdef RAM_BURST_READER_BOUNDS_EN
  logic                  cmd_err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    output cmd_ready, ram_addr_rd, out_valid, out_data, out_last, busy, done, cmd_err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    input  cmd_ready, ram_addr_rd, out_valid, out_data, out_last, busy, done, cmd_err
  );
`else
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    output cmd_ready, ram_addr_rd, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    input  cmd_ready, ram_addr_rd, out_valid, out_data, out_last, busy, done
  );
`endif
endinterface

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read-side engine for a dual-port RAM with an asynchronous read port.
//   Accepts a burst command (start address, word count), walks the RAM read
//   address and presents each word on a valid/ready stream with a last flag.
//   Sustains one word per cycle while out_ready stays high.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous, active-high reset
//     bus  - ram_burst_reader_if.master (command, RAM read port, stream, status)
//
//   Optional feature macro: RAM_BURST_READER_BOUNDS_EN
//     When defined, commands whose span runs past the top of the RAM are
//     rejected in IDLE with a one-cycle cmd_err pulse; otherwise addresses wrap.
module ram_burst_reader #(
  parameter int addr_width = 2,
  parameter int data_width = 2
) (
  input  logic                clk,
  input  logic                rst,
  ram_burst_reader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [addr_width:0]   len_zero = {(addr_width+1){1'b0}};
  localparam logic [addr_width:0]   len_one  = (addr_width+1)'(1'b1);
  localparam logic [addr_width-1:0] addr_one = addr_width'(1'b1);

  state_t                state_r,   state_next;
  logic [addr_width-1:0] addr_r,    addr_next;
  logic [addr_width:0]   rem_r,     rem_next;
  logic [data_width-1:0] data_r,    data_next;
  logic                  valid_r,   valid_next;
  logic                  last_r,    last_next;
  logic                  done_r;
  logic                  busy_r;
  logic                  ready_r;
  logic [addr_width-1:0] ram_addr_s;
  logic                  reject_s;

`ifdef RAM_BURST_READER_BOUNDS_EN
  localparam logic [addr_width+1:0] depth = {2'b01, {addr_width{1'b0}}};

  logic [addr_width+1:0] span_s;
  logic                  err_r;

  // Width-extended end-of-burst address; anything past the top of RAM is illegal.
  always_comb begin
    span_s   = {2'b00, bus.cmd_addr} + {1'b0, bus.cmd_len};
    reject_s = (span_s > depth);
  end
`else
  // Without the bounds check every command is accepted and addresses wrap.
  always_comb begin
    reject_s = 1'b0;
  end
`endif

  // Next-state, datapath and RAM address selection for the burst FSM.
  always_comb begin
    state_next = state_r;
    addr_next  = addr_r;
    rem_next   = rem_r;
    data_next  = data_r;
    valid_next = valid_r;
    last_next  = last_r;
    ram_addr_s = addr_r;

    case (state_r)
      IDLE: begin
        // The RAM is addressed straight from the command so the first word
        // can be captured on the accepting edge.
        ram_addr_s = bus.cmd_addr;
        if (bus.cmd_valid && reject_s) begin
          // Command is consumed (cmd_ready is high) but produces nothing.
          state_next = IDLE;
        end else if (bus.cmd_valid && (bus.cmd_len == len_zero)) begin
          state_next = DONE;
        end else if (bus.cmd_valid) begin
          data_next  = bus.ram_dout;
          valid_next = 1'b1;
          last_next  = (bus.cmd_len == len_one);
          addr_next  = bus.cmd_addr + addr_one;
          rem_next   = bus.cmd_len - len_one;
          state_next = READ;
        end else begin
          state_next = IDLE;
        end
      end

      READ: begin
        ram_addr_s = addr_r;
        if (valid_r && bus.out_ready && last_r) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = DONE;
        end else if ((!valid_r || bus.out_ready) && (rem_r != len_zero)) begin
          data_next  = bus.ram_dout;
          valid_next = 1'b1;
          last_next  = (rem_r == len_one);
          addr_next  = addr_r + addr_one;
          rem_next   = rem_r - len_one;
        end else if (!valid_r && (rem_r == len_zero)) begin
          // Nothing left to emit; only reachable if state was disturbed.
          state_next = DONE;
        end else begin
          // Stalled: hold data, last and address.
          state_next = READ;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= {addr_width{1'b0}};
      rem_r   <= len_zero;
      data_r  <= {data_width{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next;
      addr_r  <= addr_next;
      rem_r   <= rem_next;
      data_r  <= data_next;
      valid_r <= valid_next;
      last_r  <= last_next;
      done_r  <= (state_next == DONE);
      busy_r  <= (state_next != IDLE);
      ready_r <= (state_next == IDLE);
    end
  end

`ifdef RAM_BURST_READER_BOUNDS_EN
  // One-cycle error pulse for a command rejected in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_r == IDLE) && bus.cmd_valid && reject_s;
    end
  end

  assign bus.cmd_err = err_r;
`endif

  assign bus.cmd_ready   = ready_r;
  assign bus.ram_addr_rd = ram_addr_s;
  assign bus.out_valid   = valid_r;
  assign bus.out_data    = data_r;
  assign bus.out_last    = last_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader
//   Directed and randomized bench for ram_burst_reader (addr_width=2,
//   data_width=8). The RAM is an array in the bench read combinationally
//   through the interface; expected bursts are built as queues of
//   ram[(addr+i) mod 4].
module tb_ram_burst_reader;

  localparam int aw = 2;
  localparam int dw = 8;

  logic clk;
  logic rst;
  logic [dw-1:0] ram [4];

  int checks   = 0;
  int failures = 0;

  ram_burst_reader_if #(.addr_width(aw), .data_width(dw)) ifc ();

  ram_burst_reader #(.addr_width(aw), .data_width(dw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  assign ifc.ram_dout = ram[ifc.ram_addr_rd];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow the burst to its done pulse.
  // mode 0: out_ready always 1; 1: pattern 1,0,0 repeating; 2: random.
  task automatic run_burst(input int a, input int l, input int mode);
    int          exp_q[$];
    int          beats;
    int          dones;
    int          c;
    int          k;
    int          e;
    logic        acc;
    logic        v;
    logic        lst;
    logic        dn;
    logic        r;
    logic        hold_pending;
    logic [dw-1:0] d;
    logic [dw-1:0] pd;
    logic        pl;

    for (int i = 0; i < l; i++) exp_q.push_back(int'(ram[(a + i) % 4]));
    beats = 0;
    dones = 0;
    hold_pending = 1'b0;
    pd = '0;
    pl = 1'b0;

    ifc.cmd_addr  = aw'(a);
    ifc.cmd_len   = (aw+1)'(l);
    ifc.cmd_valid = 1'b1;
    c = 0;
    do begin
      acc = ifc.cmd_ready;
      tick();
      c++;
    end while (!acc && c < 50);
    ifc.cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 32'd1);

    k = 0;
    while (k < 200) begin
      v   = ifc.out_valid;
      d   = ifc.out_data;
      lst = ifc.out_last;
      dn  = ifc.done;
      if (hold_pending) begin
        check("hold_valid", 32'(v), 32'd1);
        check("hold_data", 32'(d), 32'(pd));
        check("hold_last", 32'(lst), 32'(pl));
      end
      if (dn) dones++;
      case (mode)
        0:       r = 1'b1;
        1:       r = ((k % 3) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ifc.out_ready = r;
      if (v && r) begin
        beats++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_data", 32'(d), 32'(e));
          check("beat_last", 32'(lst), 32'(exp_q.size() == 0));
        end else begin
          check("beats_within_len", 32'(beats), 32'(l));
        end
      end
      hold_pending = v && !r;
      pd = d;
      pl = lst;
      tick();
      k++;
      if (dn) break;
    end

    check("done_count", 32'(dones), 32'd1);
    check("beat_count", 32'(beats), 32'(l));
    check("cmd_ready_after_done", 32'(ifc.cmd_ready), 32'd1);
    check("done_one_cycle", 32'(ifc.done), 32'd0);
  endtask

  initial begin
    int a;
    int l;

    ram[0] = 8'hA0;
    ram[1] = 8'hA1;
    ram[2] = 8'hA2;
    ram[3] = 8'hA3;
    rst = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_addr  = '0;
    ifc.cmd_len   = '0;
    ifc.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_last", 32'(ifc.out_last), 32'd0);
    check("rst_out_data", 32'(ifc.out_data), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
`ifdef RAM_BURST_READER_BOUNDS_EN
    check("rst_cmd_err", 32'(ifc.cmd_err), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Burst addr=1 len=2 with exact cycle timing
    ifc.cmd_addr  = 2'd1;
    ifc.cmd_len   = 3'd2;
    ifc.cmd_valid = 1'b1;
    ifc.out_ready = 1'b1;
    #1;
    check("t1_ram_addr_idle", 32'(ifc.ram_addr_rd), 32'd1);
    tick();
    ifc.cmd_valid = 1'b0;
    check("t1_n1_valid", 32'(ifc.out_valid), 32'd1);
    check("t1_n1_data", 32'(ifc.out_data), 32'hA1);
    check("t1_n1_last", 32'(ifc.out_last), 32'd0);
    check("t1_n1_busy", 32'(ifc.busy), 32'd1);
    check("t1_n1_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
    tick();
    check("t1_n2_valid", 32'(ifc.out_valid), 32'd1);
    check("t1_n2_data", 32'(ifc.out_data), 32'hA2);
    check("t1_n2_last", 32'(ifc.out_last), 32'd1);
    tick();
    check("t1_n3_valid", 32'(ifc.out_valid), 32'd0);
    check("t1_n3_done", 32'(ifc.done), 32'd1);
    check("t1_n3_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
    tick();
    check("t1_n4_done", 32'(ifc.done), 32'd0);
    check("t1_n4_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    check("t1_n4_busy", 32'(ifc.busy), 32'd0);

    // Zero-length command: done next cycle, busy for exactly one cycle
    ifc.cmd_addr  = 2'd0;
    ifc.cmd_len   = 3'd0;
    ifc.cmd_valid = 1'b1;
    tick();
    ifc.cmd_valid = 1'b0;
    check("t0_valid", 32'(ifc.out_valid), 32'd0);
    check("t0_done", 32'(ifc.done), 32'd1);
    check("t0_busy", 32'(ifc.busy), 32'd1);
    tick();
    check("t0_busy_drop", 32'(ifc.busy), 32'd0);
    check("t0_done_drop", 32'(ifc.done), 32'd0);
    check("t0_cmd_ready", 32'(ifc.cmd_ready), 32'd1);

`ifdef RAM_BURST_READER_BOUNDS_EN
    // Out-of-range command is rejected with a single cmd_err pulse
    ifc.cmd_addr  = 2'd3;
    ifc.cmd_len   = 3'd2;
    ifc.cmd_valid = 1'b1;
    tick();
    ifc.cmd_valid = 1'b0;
    check("err_pulse", 32'(ifc.cmd_err), 32'd1);
    check("err_no_valid", 32'(ifc.out_valid), 32'd0);
    check("err_not_busy", 32'(ifc.busy), 32'd0);
    check("err_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    tick();
    check("err_cleared", 32'(ifc.cmd_err), 32'd0);
    check("err_no_done", 32'(ifc.done), 32'd0);
    run_burst(2, 2, 0);
`else
    // Wrapping burst
    run_burst(3, 3, 0);
`endif

    // Stalled burst with out_ready pattern 1,0,0
    run_burst(0, 4, 1);

    // Reset while the second word is stalled
    ifc.cmd_addr  = 2'd0;
    ifc.cmd_len   = 3'd4;
    ifc.cmd_valid = 1'b1;
    ifc.out_ready = 1'b1;
    tick();
    ifc.cmd_valid = 1'b0;
    check("rs_w0", 32'(ifc.out_data), 32'hA0);
    tick();
    ifc.out_ready = 1'b0;
    check("rs_w1", 32'(ifc.out_data), 32'hA1);
    tick();
    check("rs_w1_stalled", 32'(ifc.out_data), 32'hA1);
    check("rs_w1_valid", 32'(ifc.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_valid", 32'(ifc.out_valid), 32'd0);
    check("rs_busy", 32'(ifc.busy), 32'd0);
    check("rs_done", 32'(ifc.done), 32'd0);
    check("rs_data", 32'(ifc.out_data), 32'd0);
    check("rs_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    run_burst(2, 1, 0);

    // Randomized bursts over random RAM contents
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) ram[i] = 8'($urandom_range(0, 255));
      a = int'($urandom_range(0, 3));
      l = int'($urandom_range(0, 7));
`ifdef RAM_BURST_READER_BOUNDS_EN
      if (a + l > 4) l = 4 - a;
`endif
      run_burst(a, l, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
